// File: rtl/product_accumulator.sv
// Groups up to GROUP unsigned 16-bit products into one ACC_W-bit sum with a count and sticky overflow flag.
// Build option: define PRODUCT_ACC_SAT_EN to saturate the sum on overflow instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 24,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [3:0]       out_cnt,
    output logic             out_ovf,
    output logic             o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high,
    // on the input (in_valid/in_ready) and output (out_valid/out_ready) sides alike.

    localparam int SW = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ACC_W-1:0]  r_acc;
    logic [3:0]        r_cnt;
    logic              r_ovf;
    logic [ACC_W-1:0]  r_out_sum;
    logic [3:0]        r_out_cnt;
    logic              r_out_ovf;

    logic              w_in_fire;
    logic [SW-1:0]     w_sum_wide;
    logic              w_carry;
    logic [ACC_W-1:0]  w_acc_add;
    logic [3:0]        w_cnt_add;
    logic              w_ovf_add;
    logic              w_group_full;
    logic              w_close_add;
    logic              w_close_cur;

    // In HOLD the input is only accepted while the pending result leaves, so nothing is lost.
    assign in_ready  = !reset && ((r_state == ACCUM) || out_ready);
    assign w_in_fire = in_valid && in_ready;
    assign out_valid = (r_state == HOLD);

    assign w_sum_wide   = {1'b0, r_acc} + SW'(in_product);
    assign w_carry      = w_sum_wide[ACC_W];
    assign w_cnt_add    = r_cnt + 4'd1;
    assign w_ovf_add    = r_ovf | w_carry;
    assign w_group_full = (w_cnt_add == 4'(GROUP));

`ifdef PRODUCT_ACC_SAT_EN
    // Once saturated, any further nonzero add carries again, so the sum stays pinned.
    assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
`else
    assign w_acc_add = w_sum_wide[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_close_add  = 1'b0;
        w_close_cur  = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_in_fire && (flush || w_group_full)) begin
                    w_close_add  = 1'b1;
                    w_state_next = HOLD;
                end else if (!w_in_fire && flush && (r_cnt != 4'd0)) begin
                    w_close_cur  = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = ACCUM;
        endcase
    end

    // Accumulator is cleared on entry to HOLD so an accept on the exit cycle starts a fresh group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_close_add) begin
            r_out_sum <= w_acc_add;
            r_out_cnt <= w_cnt_add;
            r_out_ovf <= w_ovf_add;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_close_cur) begin
            r_out_sum <= r_acc;
            r_out_cnt <= r_cnt;
            r_out_ovf <= r_ovf;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_in_fire && (r_state == ACCUM)) begin
            r_acc <= w_acc_add;
            r_cnt <= w_cnt_add;
            r_ovf <= w_ovf_add;
        end else if (w_in_fire && (r_state == HOLD)) begin
            r_acc <= ACC_W'(in_product);
            r_cnt <= 4'd1;
            r_ovf <= 1'b0;
        end
    end

    assign out_sum     = r_out_sum;
    assign out_cnt     = r_out_cnt;
    assign out_ovf     = r_out_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_W, default 24: accumulator and out_sum width; legal range 17..32.
REQ-002 Parameter GROUP, default 8: products per group; legal range 2..15.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_product is valid this cycle.
REQ-006 in_ready  output  1  block can accept a product this cycle.
REQ-007 in_product  input  16  unsigned product from the upstream multiplier.
REQ-008 flush  input  1  request to close the current partial group.
REQ-009 out_valid  output  1  out_sum, out_cnt and out_ovf are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  ACC_W  sum of the group, unsigned.
REQ-012 out_cnt  output  4  number of products in the group.
REQ-013 out_ovf  output  1  the group's sum exceeded 2^ACC_W-1 at least once.

Function
REQ-014 A transfer occurs on any rising edge where valid and ready are both high; the same rule applies on the input and output sides.
REQ-015 FSM states: ACCUM and HOLD; the block enters ACCUM on reset.
REQ-016 ACCUM: in_ready=1 and out_valid=0; each accepted product adds zero-extended in_product to acc and increments cnt.
REQ-017 ACCUM to HOLD: on the cycle that accepts product number GROUP, load out_sum/out_cnt/out_ovf from the post-add values; out_valid is high from the next cycle (latency 1 clk from the last accept).
REQ-018 flush in ACCUM with cnt>0 and no accept: go to HOLD with the current acc/cnt.
REQ-019 flush in ACCUM with an accept in the same cycle: include that product, then go to HOLD.
REQ-020 flush in ACCUM with cnt=0 and no accept: ignored.
REQ-021 flush in HOLD: ignored.
REQ-022 HOLD: out_valid=1; out_sum, out_cnt and out_ovf hold stable until transferred; in_ready=out_ready (combinational).
REQ-023 HOLD with out_ready=1 and no input accept: go to ACCUM with acc=0, cnt=0, ovf=0.
REQ-024 HOLD with out_ready=1 and an accepted input: go to ACCUM with acc=in_product, cnt=1, ovf=0; no bubble and no lost product.
REQ-025 HOLD with out_ready=0: in_ready=0; the input stalls and no state changes.
REQ-026 Addition is computed ACC_W+1 bits wide; a carry out sets the sticky ovf bit for the current group.
REQ-027 The overflowing sum wraps modulo 2^ACC_W unless SAT_EN is defined (see REQ-032).
REQ-028 in_product is ignored whenever in_valid=0 or in_ready=0.

Reset
REQ-029 Reset asserted: state=ACCUM, acc=0, cnt=0, ovf=0, out_sum=0, out_cnt=0, out_ovf=0, out_valid=0.
REQ-030 While reset is asserted: in_ready=0.
REQ-031 Reset mid-group or in HOLD discards the partial or pending result; the first accept after deassertion starts a new group at cnt=1.

Configuration
REQ-032 Macro PRODUCT_ACC_SAT_EN defined: on carry out, acc saturates to 2^ACC_W-1, stays there for the rest of the group, and ovf is set.
REQ-033 Macro PRODUCT_ACC_SAT_EN undefined: wrap-around per REQ-027; ovf is still reported.

Verification
REQ-034 GROUP=8; 8 back-to-back products 0x0100..0x0800 with out_ready=1 -> one out_valid pulse, out_sum=0x002400, out_cnt=8, out_ovf=0.
REQ-035 Products 5 and 7, then flush alone -> out_sum=12, out_cnt=2; a flush with cnt=0 produces no output.
REQ-036 Hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0 and out_sum stable; release -> next product 0x0003 starts a new group with acc=3, cnt=1.
REQ-037 ACC_W=17; 3 products of 0xFFFF -> wrap build: out_sum=0x0FFFD, out_ovf=1; SAT_EN build: out_sum=0x1FFFF, out_ovf=1.
REQ-038 Assert reset after 4 of 8 products -> all outputs 0; the next 8 products give only their own sum with out_cnt=8.
REQ-039 Flush together with an accept of 0x0010 while cnt=2 (acc=0x20) -> out_sum=0x30, out_cnt=3.
